// File: rtl/hamming_secded_decoder.sv
// Walks NUM_WORDS Hamming(16,11) SECDED codewords in memory, writing corrected data plus status; optional HAMMING_STATS_EN adds error counters.
// Latency: 5 cycles per word, ack rises 5*NUM_WORDS+1 cycles after the req-accepting edge.
// Backpressure: none; memory is assumed always ready, req is ignored while busy.
module hamming_secded_decoder #(
    parameter int NUM_WORDS = 15,
    parameter int SRC_BASE  = 30,
    parameter int DST_BASE  = 0,
    parameter int AW        = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          req,
    output logic          ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd_en,
    input  logic [7:0]    mem_rdata,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wdata,
    output logic [3:0]    err1_cnt,
    output logic [3:0]    err2_cnt
);

    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [AW-1:0] SRC_A = AW'(SRC_BASE);
    localparam logic [AW-1:0] DST_A = AW'(DST_BASE);
    localparam logic [IW-1:0] LAST  = IW'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_LO, S_RD_HI, S_DECODE, S_WR_LO, S_WR_HI, S_DONE
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [7:0]      lo_byte_q;
    logic [7:0]      hi_res_q;
    logic            ack_q;
    logic [AW-1:0]   addr_q;
    logic            rd_q;
    logic            wr_q;
    logic [7:0]      wdata_q;

    logic [IW-1:0]   idx_d;
    logic [15:0]     cw_d;
    logic [3:0]      syn_d;
    logic            par_d;
    logic [15:0]     fixed_d;
    logic [1:0]      flag_d;
    logic [7:0]      lo_res_d;
    logic [7:0]      hi_res_d;

    assign idx_d = idx_q + 1'b1;

    // Decode uses the hi byte straight off the read port during DECODE.
    always_comb begin
        cw_d     = {mem_rdata, lo_byte_q};
        syn_d[0] = ^(cw_d & 16'hAAAA);
        syn_d[1] = ^(cw_d & 16'hCCCC);
        syn_d[2] = ^(cw_d & 16'hF0F0);
        syn_d[3] = ^(cw_d & 16'hFF00);
        par_d    = ^cw_d;
        fixed_d  = cw_d;
        flag_d   = 2'b00;
        if (par_d) begin
            fixed_d = cw_d ^ (16'h0001 << syn_d);
            flag_d  = 2'b01;
        end else if (syn_d != 4'd0) begin
            flag_d  = 2'b10;
        end
        lo_res_d = {fixed_d[12], fixed_d[11], fixed_d[10], fixed_d[9],
                    fixed_d[7], fixed_d[6], fixed_d[5], fixed_d[3]};
        hi_res_d = {flag_d, 3'b000, fixed_d[15], fixed_d[14], fixed_d[13]};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            lo_byte_q <= '0;
            hi_res_q  <= '0;
            ack_q     <= 1'b0;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
        end else begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        ack_q   <= 1'b0;
                        idx_q   <= '0;
                        rd_q    <= 1'b1;
                        addr_q  <= SRC_A;
                        state_q <= S_RD_LO;
                    end
                end
                S_RD_LO: begin
                    rd_q    <= 1'b1;
                    addr_q  <= SRC_A + AW'({idx_q, 1'b1});
                    state_q <= S_RD_HI;
                end
                S_RD_HI: begin
                    lo_byte_q <= mem_rdata;
                    state_q   <= S_DECODE;
                end
                S_DECODE: begin
                    hi_res_q <= hi_res_d;
                    wr_q     <= 1'b1;
                    addr_q   <= DST_A + AW'({idx_q, 1'b0});
                    wdata_q  <= lo_res_d;
                    state_q  <= S_WR_LO;
                end
                S_WR_LO: begin
                    wr_q    <= 1'b1;
                    addr_q  <= DST_A + AW'({idx_q, 1'b1});
                    wdata_q <= hi_res_q;
                    state_q <= S_WR_HI;
                end
                S_WR_HI: begin
                    if (idx_q == LAST) begin
                        state_q <= S_DONE;
                    end else begin
                        idx_q   <= idx_d;
                        rd_q    <= 1'b1;
                        addr_q  <= SRC_A + AW'({idx_d, 1'b0});
                        state_q <= S_RD_LO;
                    end
                end
                S_DONE: begin
                    ack_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack       = ack_q;
    assign mem_addr  = addr_q;
    assign mem_rd_en = rd_q;
    assign mem_wr_en = wr_q;
    assign mem_wdata = wdata_q;

`ifdef HAMMING_STATS_EN
    logic [3:0] err1_q;
    logic [3:0] err2_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err1_q <= '0;
            err2_q <= '0;
        end else if (state_q == S_IDLE && req) begin
            err1_q <= '0;
            err2_q <= '0;
        end else if (state_q == S_WR_HI) begin
            if (hi_res_q[7:6] == 2'b01 && err1_q != 4'hF) err1_q <= err1_q + 4'd1;
            if (hi_res_q[7:6] == 2'b10 && err2_q != 4'hF) err2_q <= err2_q + 4'd1;
        end
    end

    assign err1_cnt = err1_q;
    assign err2_cnt = err2_q;
`else
    assign err1_cnt = 4'h0;
    assign err2_cnt = 4'h0;
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Randomized bench for hamming_secded_decoder against a position-indexed SECDED model.
module tb_hamming_secded_decoder;

    localparam int NW  = 15;
    localparam int SRC = 30;
    localparam int DST = 0;
    localparam int DPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    logic       clock = 1'b0;
    logic       reset_n;
    logic       req;
    logic       ack;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;
    logic [3:0] err1_cnt;
    logic [3:0] err2_cnt;

    logic [7:0]  mem [256];
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = 8'h00;
    logic [7:0]  ld_dat = 8'h00;
    logic [15:0] src_w [NW];
    int          n_checks = 0;
    int          n_errors = 0;
    int          overlap = 0;

    hamming_secded_decoder #(.NUM_WORDS(NW), .SRC_BASE(SRC), .DST_BASE(DST), .AW(8)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req),
        .ack      (ack),
        .mem_addr (mem_addr),
        .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata),
        .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata),
        .err1_cnt (err1_cnt),
        .err2_cnt (err2_cnt)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ld_en) mem[ld_addr] <= ld_dat;
        else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    always @(negedge clock) if (mem_rd_en && mem_wr_en) overlap++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Syndrome = XOR of the indices of all set bits; returns {hi, lo} result bytes.
    function automatic logic [15:0] ref_decode(input logic [15:0] cw);
        logic [15:0] c;
        logic [10:0] d;
        logic [1:0]  f;
        int          syn;
        c = cw;
        syn = 0;
        for (int p = 0; p < 16; p++) if (c[p]) syn ^= p;
        if (^c) begin
            c[syn] = ~c[syn];
            f = 2'b01;
        end else if (syn != 0) f = 2'b10;
        else f = 2'b00;
        for (int j = 0; j < 11; j++) d[j] = c[DPOS[j]];
        return {f, 3'b000, d[10:8], d[7:0]};
    endfunction

    function automatic logic [15:0] rand_word();
        logic [15:0] c;
        logic [10:0] d;
        int          syn;
        int          nerr;
        int          b1;
        int          b2;
        d = 11'($urandom);
        c = '0;
        for (int j = 0; j < 11; j++) c[DPOS[j]] = d[j];
        syn = 0;
        for (int p = 0; p < 16; p++) if (c[p]) syn ^= p;
        for (int k = 0; k < 4; k++) c[1 << k] = syn[k];
        c[0] = ^c;
        nerr = $urandom_range(0, 2);
        b1 = $urandom_range(0, 15);
        b2 = (b1 + $urandom_range(1, 15)) % 16;
        if (nerr >= 1) c[b1] = ~c[b1];
        if (nerr == 2) c[b2] = ~c[b2];
        return c;
    endfunction

    task automatic load_mem();
        for (int i = 0; i < 2 * NW; i++) begin
            @(negedge clock);
            ld_en = 1'b1;
            ld_addr = 8'(SRC + i);
            ld_dat = (i % 2 == 0) ? src_w[i/2][7:0] : src_w[i/2][15:8];
            @(negedge clock);
            ld_addr = 8'(DST + i);
            ld_dat = 8'hEE;
        end
        @(negedge clock);
        ld_en = 1'b0;
    endtask

    task automatic check_results(input string tag);
        int e1;
        int e2;
        logic [15:0] exp;
        e1 = 0;
        e2 = 0;
        for (int i = 0; i < NW; i++) begin
            exp = ref_decode(src_w[i]);
            check($sformatf("%s_w%0d", tag, i), {mem[DST+2*i+1], mem[DST+2*i]}, exp);
            if (exp[15:14] == 2'b01) e1++;
            if (exp[15:14] == 2'b10) e2++;
        end
`ifndef HAMMING_STATS_EN
        e1 = 0;
        e2 = 0;
`endif
        check({tag, "_err1"}, err1_cnt, e1);
        check({tag, "_err2"}, err2_cnt, e2);
    endtask

    task automatic run_job(input string tag, input bit pulse20);
        int lat;
        load_mem();
        @(negedge clock);
        req = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (ack) break;
            req = pulse20 && (lat == 19);
        end
        req = 1'b0;
        check({tag, "_latency"}, lat, 76);
        repeat (3) @(negedge clock);
        check({tag, "_ack_held"}, ack, 1);
        check({tag, "_idle_strobes"}, {mem_rd_en, mem_wr_en}, 0);
        check_results(tag);
    endtask

    initial begin
        int untouched;
        reset_n = 1'b0;
        req = 1'b0;
        #1;
        check("rst_ack", ack, 0);
        check("rst_rd", mem_rd_en, 0);
        check("rst_wr", mem_wr_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_err1", err1_cnt, 0);
        check("rst_err2", err2_cnt, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Directed words from the known-answer table lead the first run.
        for (int i = 0; i < NW; i++) src_w[i] = rand_word();
        src_w[0] = 16'hB42D;
        src_w[1] = 16'hB62D;
        src_w[2] = 16'hB42C;
        src_w[3] = 16'hB625;
        run_job("dir", 1'b0);
        check("kat_clean", {mem[DST+1], mem[DST]}, 16'h05A3);
        check("kat_single", {mem[DST+3], mem[DST+2]}, 16'h45A3);
        check("kat_p0", {mem[DST+5], mem[DST+4]}, 16'h45A3);
        check("kat_double", {mem[DST+7], mem[DST+6]}, 16'h85B2);

        for (int i = 0; i < NW; i++) src_w[i] = rand_word();
        run_job("rnd", 1'b1);

        // Abort mid-run: word 2 is in DECODE, so only words 0 and 1 reached memory.
        for (int i = 0; i < NW; i++) src_w[i] = rand_word();
        load_mem();
        @(negedge clock);
        req = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req = 1'b0;
        repeat (12) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("abort_ack", ack, 0);
        check("abort_strobes", {mem_rd_en, mem_wr_en}, 0);
        check("abort_addr", mem_addr, 0);
        check("abort_wdata", mem_wdata, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        check("abort_w0", {mem[DST+1], mem[DST]}, ref_decode(src_w[0]));
        check("abort_w1", {mem[DST+3], mem[DST+2]}, ref_decode(src_w[1]));
        untouched = 0;
        for (int i = 2; i < NW; i++)
            if ({mem[DST+2*i+1], mem[DST+2*i]} == 16'hEEEE) untouched++;
        check("abort_untouched", untouched, NW - 2);
        check("abort_idle_ack", ack, 0);

        for (int i = 0; i < NW; i++) src_w[i] = rand_word();
        run_job("rerun", 1'b0);

        check("rd_wr_exclusive", overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
